// File: rtl/te_block_gen.sv
`default_nettype none
// ============================================================================
// Module  : te_block_gen
// Groups up to NRET retired instructions per cycle into trace blocks and
// queues closed blocks in an output FIFO with a valid/ready handshake.
// Rev     : 1.0
// ============================================================================
module te_block_gen #(
    parameter int NRET        = 2,
    parameter int XLEN        = 64,
    parameter int IRETIRE_LEN = 32,
    parameter int ITYPE_LEN   = 3,
    parameter int CAUSE_LEN   = 5,
    parameter int PRIV_LEN    = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NRET-1:0]           lane_valid_i,
    input  logic [NRET*ITYPE_LEN-1:0] lane_itype_i,
    input  logic [NRET-1:0]           lane_compr_i,
    input  logic [NRET*XLEN-1:0]      lane_pc_i,
    input  logic [NRET*PRIV_LEN-1:0]  lane_priv_i,
    input  logic [CAUSE_LEN-1:0]      cause_i,
    input  logic [XLEN-1:0]           tval_i,
    input  logic                      flush_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [XLEN-1:0]           iaddr_o,
    output logic [IRETIRE_LEN-1:0]    iretire_o,
    output logic                      ilastsize_o,
    output logic [ITYPE_LEN-1:0]      itype_o,
    output logic [CAUSE_LEN-1:0]      cause_o,
    output logic [XLEN-1:0]           tval_o,
    output logic [PRIV_LEN-1:0]       priv_o
);

    localparam int c_BLK_W = 2*XLEN + IRETIRE_LEN + 1 + ITYPE_LEN + CAUSE_LEN + PRIV_LEN;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_NSLOT = NRET + 1;
    localparam logic [IRETIRE_LEN-1:0] c_SAT       = {{(IRETIRE_LEN-1){1'b1}}, 1'b0};
    localparam logic [ITYPE_LEN-1:0]   c_ITYPE_EXC = ITYPE_LEN'(1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_OPEN  = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [XLEN-1:0]         r_blk_addr, w_blk_addr;
    logic [IRETIRE_LEN-1:0]  r_blk_cnt, w_blk_cnt;
    logic                    r_blk_last, w_blk_last;
    logic [PRIV_LEN-1:0]     r_blk_priv, w_blk_priv;

    logic [c_BLK_W-1:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    // One slot per lane close plus one for the flush close, packed in close order.
    logic [c_NSLOT-1:0]      w_slot_vld;
    logic [c_BLK_W-1:0]      w_slot_data [c_NSLOT];
    logic [c_PTR_W-1:0]      w_slot_pos  [c_NSLOT];
    logic [c_CNT_W-1:0]      w_push_num;
    logic                    w_in_ready;
    logic                    w_pop;
    logic [c_BLK_W-1:0]      w_head;

    function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_PTR_W-1:0] p, input int n);
        int t;
        t = int'(p) + n;
        if (t >= FIFO_DEPTH) t = t - FIFO_DEPTH;
        return c_PTR_W'(t);
    endfunction

    assign w_in_ready  = (32'(r_count) + c_NSLOT) <= FIFO_DEPTH;
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = (r_count != '0);
    assign w_pop       = out_valid_o & out_ready_i;
    assign w_head      = out_valid_o ? r_mem[r_rd_ptr] : '0;
    assign {iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o} = w_head;

    always_comb begin
        int n;
        n           = 0;
        w_state_nxt = r_state;
        w_blk_addr  = r_blk_addr;
        w_blk_cnt   = r_blk_cnt;
        w_blk_last  = r_blk_last;
        w_blk_priv  = r_blk_priv;
        w_slot_vld  = '0;
        for (int s = 0; s < c_NSLOT; s++) begin
            w_slot_data[s] = '0;
            w_slot_pos[s]  = '0;
        end
        if (w_in_ready) begin
            for (int k = 0; k < NRET; k++) begin
                if (lane_valid_i[k]) begin
                    if (w_state_nxt == S_EMPTY) begin
                        w_blk_addr  = lane_pc_i[k*XLEN +: XLEN];
                        w_blk_cnt   = '0;
                        w_state_nxt = S_OPEN;
                    end
                    w_blk_cnt  = w_blk_cnt + (lane_compr_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
                    w_blk_last = ~lane_compr_i[k];
                    w_blk_priv = lane_priv_i[k*PRIV_LEN +: PRIV_LEN];
                    if ((lane_itype_i[k*ITYPE_LEN +: ITYPE_LEN] != '0) || (w_blk_cnt >= c_SAT)) begin
                        w_slot_vld[k]  = 1'b1;
                        w_slot_pos[k]  = f_wrap(r_wr_ptr, n);
                        w_slot_data[k] = {w_blk_addr, w_blk_cnt, w_blk_last,
                                          lane_itype_i[k*ITYPE_LEN +: ITYPE_LEN],
                                          (lane_itype_i[k*ITYPE_LEN +: ITYPE_LEN] == c_ITYPE_EXC) ? cause_i : '0,
                                          (lane_itype_i[k*ITYPE_LEN +: ITYPE_LEN] == c_ITYPE_EXC) ? tval_i  : '0,
                                          w_blk_priv};
                        n           = n + 1;
                        w_state_nxt = S_EMPTY;
                        w_blk_cnt   = '0;
                    end
                end
            end
            // Flush sees the block as left by the last lane of this cycle.
            if (flush_i && (w_state_nxt == S_OPEN)) begin
                w_slot_vld[NRET]  = 1'b1;
                w_slot_pos[NRET]  = f_wrap(r_wr_ptr, n);
                w_slot_data[NRET] = {w_blk_addr, w_blk_cnt, w_blk_last, {ITYPE_LEN{1'b0}},
                                     {CAUSE_LEN{1'b0}}, {XLEN{1'b0}}, w_blk_priv};
                n           = n + 1;
                w_state_nxt = S_EMPTY;
                w_blk_cnt   = '0;
            end
        end
        w_push_num = c_CNT_W'(n);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_EMPTY;
            r_blk_addr <= '0;
            r_blk_cnt  <= '0;
            r_blk_last <= 1'b0;
            r_blk_priv <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_blk_addr <= w_blk_addr;
            r_blk_cnt  <= w_blk_cnt;
            r_blk_last <= w_blk_last;
            r_blk_priv <= w_blk_priv;
            r_wr_ptr   <= f_wrap(r_wr_ptr, 32'(w_push_num));
            if (w_pop) r_rd_ptr <= f_wrap(r_rd_ptr, 1);
            r_count    <= r_count + w_push_num - c_CNT_W'(w_pop);
        end
    end

    // Storage is not reset; reads are masked by out_valid_o.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < c_NSLOT; s++) begin
            if (rst_ni && w_slot_vld[s]) r_mem[w_slot_pos[s]] <= w_slot_data[s];
        end
    end

endmodule
`default_nettype wire
